chromakey_compositor: RTL and testbench



---
 rtl/chromakey_compositor.sv | 148 ++++++++++++++
 tb/tb_chromakey_compositor.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chromakey_compositor.sv
// Chroma-key compositor: majority-filters the key flag, swaps keyed pixels for game pixels, counts ROI foreground.
// Latency: 2 cycles from input sample to de_out/rgb_out/x_out/y_out; fg_count/fg_valid 1 cycle after frame_start.
// Backpressure: none; the stream advances every cycle and blanking simply flows through as invalid entries.
//
// Ports:
//   clk, reset_n                     pixel clock, asynchronous active-low reset
//   de_in, cam_rgb, bg_pixel_in,     input pixel stream: qualifier, RGB565 camera pixel,
//   game_rgb, x_in, y_in             raw key flag, game-scene pixel, pixel coordinates
//   key_en                           1 = composite, 0 = camera pass-through
//   frame_start                      one-cycle frame boundary pulse
//   de_out, rgb_out, x_out, y_out    composited output stream
//   fg_count, fg_valid               ROI foreground count of the last frame and its update strobe
module chromakey_compositor #(
   parameter int ROI_X0 = 0,
   parameter int ROI_X1 = 639,
   parameter int ROI_Y0 = 0,
   parameter int ROI_Y1 = 479,
   parameter int CNT_W  = 19
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             de_in,
   input  logic [15:0]      cam_rgb,
   input  logic             bg_pixel_in,
   input  logic [15:0]      game_rgb,
   input  logic [9:0]       x_in,
   input  logic [9:0]       y_in,
   input  logic             key_en,
   input  logic             frame_start,
   output logic             de_out,
   output logic [15:0]      rgb_out,
   output logic [9:0]       x_out,
   output logic [9:0]       y_out,
   output logic [CNT_W-1:0] fg_count,
   output logic             fg_valid
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // S0 = newest (right neighbour), S1 = center, S2 = left neighbour.
   // Only the valid/key fields of the left entry are ever consumed.
   logic        s0_vld, s1_vld, s2_vld;
   logic        s0_key, s1_key, s2_key;
   logic [15:0] s0_cam, s1_cam;
   logic [15:0] s0_game, s1_game;
   logic [9:0]  s0_x, s1_x;
   logic [9:0]  s0_y, s1_y;

   logic [CNT_W-1:0] acc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s0_vld  <= 1'b0;
         s1_vld  <= 1'b0;
         s2_vld  <= 1'b0;
         s0_key  <= 1'b0;
         s1_key  <= 1'b0;
         s2_key  <= 1'b0;
         s0_cam  <= '0;
         s1_cam  <= '0;
         s0_game <= '0;
         s1_game <= '0;
         s0_x    <= '0;
         s1_x    <= '0;
         s0_y    <= '0;
         s1_y    <= '0;
      end else begin
         s0_vld  <= de_in;
         s0_key  <= bg_pixel_in;
         s0_cam  <= cam_rgb;
         s0_game <= game_rgb;
         s0_x    <= x_in;
         s0_y    <= y_in;
         s1_vld  <= s0_vld;
         s1_key  <= s0_key;
         s1_cam  <= s0_cam;
         s1_game <= s0_game;
         s1_x    <= s0_x;
         s1_y    <= s0_y;
         s2_vld  <= s1_vld;
         s2_key  <= s1_key;
      end
   end

   // A missing neighbour (line edge / blanking) mirrors the center, so an
   // edge pixel keeps its raw key while an interior isolated pixel flips.
   logic lft_key, rgt_key, keyed;
   always_comb begin
      lft_key = s2_vld ? s2_key : s1_key;
      rgt_key = s0_vld ? s0_key : s1_key;
      keyed   = (lft_key & s1_key) | (s1_key & rgt_key) | (lft_key & rgt_key);
   end

   // Coordinates widened to signed int so ROI bounds of 0 compare cleanly.
   int  px, py;
   logic in_roi, fg_inc;
   always_comb begin
      px     = {22'd0, s1_x};
      py     = {22'd0, s1_y};
      in_roi = (px >= ROI_X0) && (px <= ROI_X1) && (py >= ROI_Y0) && (py <= ROI_Y1);
      fg_inc = s1_vld && !keyed && in_roi;
   end

   // Accumulator value including this cycle's increment, saturating.
   logic [CNT_W-1:0] acc_upd;
   always_comb begin
      acc_upd = acc;
      if (fg_inc && (acc != CNT_MAX)) acc_upd = acc + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         de_out  <= 1'b0;
         rgb_out <= '0;
         x_out   <= '0;
         y_out   <= '0;
      end else begin
         de_out  <= s1_vld;
         x_out   <= s1_x;
         y_out   <= s1_y;
         if (!s1_vld)
            rgb_out <= 16'h0000;
         else if (key_en && keyed)
            rgb_out <= s1_game;
         else
            rgb_out <= s1_cam;
      end
   end

   // The increment coinciding with frame_start belongs to the closing frame;
   // the next cycle's increment starts the new frame at 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= '0;
         fg_count <= '0;
         fg_valid <= 1'b0;
      end else begin
         fg_valid <= frame_start;
         if (frame_start) begin
            fg_count <= acc_upd;
            acc      <= '0;
         end else begin
            acc      <= acc_upd;
         end
      end
   end

endmodule

// File: tb/tb_chromakey_compositor.sv
module tb_chromakey_compositor;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        de_in = 1'b0;
   logic [15:0] cam_rgb = '0;
   logic        bg_pixel_in = 1'b0;
   logic [15:0] game_rgb = '0;
   logic [9:0]  x_in = '0;
   logic [9:0]  y_in = '0;
   logic        key_en = 1'b0;
   logic        frame_start = 1'b0;

   logic        de_out, de_out_s;
   logic [15:0] rgb_out, rgb_out_s;
   logic [9:0]  x_out, y_out, x_out_s, y_out_s;
   logic [18:0] fg_count;
   logic [3:0]  fg_count_s;
   logic        fg_valid, fg_valid_s;

   int checks = 0;
   int errors = 0;

   logic [15:0] q_rgb[$];
   logic [9:0]  q_x[$];

   always #5 clk = ~clk;

   chromakey_compositor #(
      .ROI_X0(10), .ROI_X1(19), .ROI_Y0(5), .ROI_Y1(6), .CNT_W(19)
   ) dut (
      .clk(clk), .reset_n(reset_n), .de_in(de_in), .cam_rgb(cam_rgb),
      .bg_pixel_in(bg_pixel_in), .game_rgb(game_rgb), .x_in(x_in), .y_in(y_in),
      .key_en(key_en), .frame_start(frame_start), .de_out(de_out), .rgb_out(rgb_out),
      .x_out(x_out), .y_out(y_out), .fg_count(fg_count), .fg_valid(fg_valid)
   );

   // Full-frame ROI, 4-bit counter: exercises saturation.
   chromakey_compositor #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset_n(reset_n), .de_in(de_in), .cam_rgb(cam_rgb),
      .bg_pixel_in(bg_pixel_in), .game_rgb(game_rgb), .x_in(x_in), .y_in(y_in),
      .key_en(key_en), .frame_start(frame_start), .de_out(de_out_s), .rgb_out(rgb_out_s),
      .x_out(x_out_s), .y_out(y_out_s), .fg_count(fg_count_s), .fg_valid(fg_valid_s)
   );

   always @(negedge clk) begin
      if (de_out) begin
         q_rgb.push_back(rgb_out);
         q_x.push_back(x_out);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      de_in = 1'b0;
      repeat (n) step();
   endtask

   task automatic send_line(input int n, input logic [63:0] flags, input logic [9:0] y);
      for (int i = 0; i < n; i++) begin
         de_in       = 1'b1;
         bg_pixel_in = flags[i];
         x_in        = i[9:0];
         y_in        = y;
         step();
      end
      de_in       = 1'b0;
      bg_pixel_in = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) step();
      checks++;
      if (de_out !== 1'b0 || rgb_out !== 16'h0 || x_out !== 10'h0 || y_out !== 10'h0 ||
          fg_count !== 19'h0 || fg_valid !== 1'b0 || fg_count_s !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: de=%b rgb=%h x=%h y=%h cnt=%h vld=%b cnt_s=%h, required all zero",
                  de_out, rgb_out, x_out, y_out, fg_count, fg_valid, fg_count_s);
      end
      reset_n = 1'b1;
      idle(2);
   endtask

   task automatic test_passthrough();
      logic        exp_de;
      logic [15:0] exp_rgb;
      logic [9:0]  exp_x;
      key_en   = 1'b0;
      cam_rgb  = 16'hF800;
      game_rgb = 16'h001F;
      for (int c = 0; c < 12; c++) begin
         int t;
         de_in       = (c < 8);
         bg_pixel_in = 1'b1;
         x_in        = c[9:0];
         y_in        = 10'd1;
         step();
         t       = c - 2;
         exp_de  = (c >= 2 && c <= 9);
         exp_rgb = exp_de ? 16'hF800 : 16'h0000;
         exp_x   = t[9:0];
         checks++;
         if (de_out !== exp_de || rgb_out !== exp_rgb || (exp_de && x_out !== exp_x)) begin
            errors++;
            $display("FAIL passthrough cyc %0d: de=%b rgb=%h x=%0d, required de=%b rgb=%h x=%0d",
                     c, de_out, rgb_out, x_out, exp_de, exp_rgb, exp_x);
         end
      end
      idle(3);
   endtask

   task automatic test_composite();
      logic [15:0] got;
      key_en   = 1'b1;
      cam_rgb  = 16'hF800;
      game_rgb = 16'h001F;
      // flags 1,1,0,1,1: the isolated 0 is flipped
      q_rgb.delete(); q_x.delete();
      send_line(5, 64'b11011, 10'd0);
      idle(4);
      checks++;
      if (q_rgb.size() != 5) begin
         errors++;
         $display("FAIL composite_a_len: got %0d pixels, required 5", q_rgb.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < q_rgb.size()) ? q_rgb[i] : 16'hxxxx;
         checks++;
         if (got !== 16'h001F) begin
            errors++;
            $display("FAIL composite_a px%0d: got %h, required 001F", i, got);
         end
      end
      // flags 0,0,1,0,0: the isolated 1 is flipped
      q_rgb.delete(); q_x.delete();
      send_line(5, 64'b00100, 10'd0);
      idle(4);
      checks++;
      if (q_rgb.size() != 5) begin
         errors++;
         $display("FAIL composite_b_len: got %0d pixels, required 5", q_rgb.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < q_rgb.size()) ? q_rgb[i] : 16'hxxxx;
         checks++;
         if (got !== 16'hF800) begin
            errors++;
            $display("FAIL composite_b px%0d: got %h, required F800", i, got);
         end
      end
   endtask

   task automatic test_line_edges();
      logic [15:0] got;
      logic [9:0]  gx;
      key_en = 1'b1;
      q_rgb.delete(); q_x.delete();
      send_line(2, 64'b01, 10'd3);   // flags 1,0
      idle(4);
      for (int i = 0; i < 2; i++) begin
         got = (i < q_rgb.size()) ? q_rgb[i] : 16'hxxxx;
         gx  = (i < q_x.size()) ? q_x[i] : 10'hxxx;
         checks++;
         if (got !== ((i == 0) ? 16'h001F : 16'hF800) || gx !== i[9:0]) begin
            errors++;
            $display("FAIL edge2 px%0d: got rgb=%h x=%0d, required rgb=%h x=%0d",
                     i, got, gx, (i == 0) ? 16'h001F : 16'hF800, i);
         end
      end
      q_rgb.delete(); q_x.delete();
      send_line(1, 64'b1, 10'd4);
      idle(4);
      got = (q_rgb.size() == 1) ? q_rgb[0] : 16'hxxxx;
      checks++;
      if (got !== 16'h001F) begin
         errors++;
         $display("FAIL edge1 single: got %h (n=%0d), required 001F", got, q_rgb.size());
      end
      // blanking with live camera data must still output zero
      checks++;
      if (de_out !== 1'b0 || rgb_out !== 16'h0000) begin
         errors++;
         $display("FAIL blanking: de=%b rgb=%h, required de=0 rgb=0000", de_out, rgb_out);
      end
   endtask

   task automatic test_roi();
      idle(2);
      frame_start = 1'b1; step(); frame_start = 1'b0; step();
      for (int y = 0; y < 8; y++) begin
         send_line(24, 64'h0, y[9:0]);
         idle(2);
      end
      idle(3);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      checks++;
      if (fg_valid !== 1'b1 || fg_count !== 19'd20) begin
         errors++;
         $display("FAIL roi_count: vld=%b cnt=%0d, required vld=1 cnt=20", fg_valid, fg_count);
      end
      checks++;
      if (fg_valid_s !== 1'b1 || fg_count_s !== 4'd15) begin
         errors++;
         $display("FAIL roi_sat_frame: vld=%b cnt=%0d, required vld=1 cnt=15", fg_valid_s, fg_count_s);
      end
      step();
      checks++;
      if (fg_valid !== 1'b0 || fg_count !== 19'd20) begin
         errors++;
         $display("FAIL roi_pulse_width: vld=%b cnt=%0d, required vld=0 cnt=20", fg_valid, fg_count);
      end
      for (int y = 0; y < 8; y++) begin
         send_line(24, 64'hFFFF_FFFF_FFFF_FFFF, y[9:0]);
         idle(2);
      end
      idle(3);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      checks++;
      if (fg_valid !== 1'b1 || fg_count !== 19'd0) begin
         errors++;
         $display("FAIL roi_keyed_frame: vld=%b cnt=%0d, required vld=1 cnt=0", fg_valid, fg_count);
      end
      step();
   endtask

   task automatic test_saturation();
      send_line(14, 64'h0, 10'd5);
      idle(4);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      checks++;
      if (fg_count_s !== 4'd14 || fg_count !== 19'd4) begin
         errors++;
         $display("FAIL sat_below: cnt_s=%0d cnt=%0d, required cnt_s=14 cnt=4", fg_count_s, fg_count);
      end
      step();
      send_line(40, 64'h0, 10'd5);
      idle(4);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      checks++;
      if (fg_count_s !== 4'd15 || fg_count !== 19'd10) begin
         errors++;
         $display("FAIL sat_40: cnt_s=%0d cnt=%0d, required cnt_s=15 cnt=10", fg_count_s, fg_count);
      end
      step();
   endtask

   task automatic test_reset_midline();
      key_en   = 1'b1;
      cam_rgb  = 16'hF800;
      game_rgb = 16'h001F;
      for (int i = 0; i < 3; i++) begin
         de_in = 1'b1; bg_pixel_in = 1'b0; x_in = i[9:0]; y_in = 10'd2;
         step();
      end
      checks++;
      if (de_out !== 1'b1 || rgb_out !== 16'hF800) begin
         errors++;
         $display("FAIL pre_reset: de=%b rgb=%h, required de=1 rgb=F800", de_out, rgb_out);
      end
      de_in = 1'b1; x_in = 10'd3;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (de_out !== 1'b0 || rgb_out !== 16'h0 || x_out !== 10'h0 || y_out !== 10'h0 ||
          fg_count !== 19'h0 || fg_valid !== 1'b0 || fg_count_s !== 4'h0) begin
         errors++;
         $display("FAIL midline_reset: de=%b rgb=%h x=%h y=%h cnt=%h vld=%b cnt_s=%h, required all zero",
                  de_out, rgb_out, x_out, y_out, fg_count, fg_valid, fg_count_s);
      end
      idle(2);
      reset_n = 1'b1;
      q_rgb.delete(); q_x.delete();
      send_line(2, 64'b11, 10'd2);
      idle(4);
      checks++;
      if (q_rgb.size() != 2 || q_rgb[0] !== 16'h001F || q_rgb[1] !== 16'h001F) begin
         errors++;
         $display("FAIL post_reset_line: n=%0d first=%h, required n=2 both 001F",
                  q_rgb.size(), (q_rgb.size() > 0) ? q_rgb[0] : 16'hxxxx);
      end
   endtask

   task automatic test_back_to_back();
      idle(2);
      frame_start = 1'b1; step(); frame_start = 1'b0; step();
      // pixel 0 increments with the first pulse, pixel 1 with the second
      send_line(2, 64'h0, 10'd0);
      frame_start = 1'b1; step();
      checks++;
      if (fg_valid_s !== 1'b1 || fg_count_s !== 4'd1) begin
         errors++;
         $display("FAIL b2b_first: vld=%b cnt=%0d, required vld=1 cnt=1", fg_valid_s, fg_count_s);
      end
      step();
      checks++;
      if (fg_valid_s !== 1'b1 || fg_count_s !== 4'd1 || fg_valid !== 1'b1 || fg_count !== 19'd0) begin
         errors++;
         $display("FAIL b2b_second: vld_s=%b cnt_s=%0d vld=%b cnt=%0d, required 1/1/1/0",
                  fg_valid_s, fg_count_s, fg_valid, fg_count);
      end
      frame_start = 1'b0; step();
      checks++;
      if (fg_valid_s !== 1'b0 || fg_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: vld_s=%b vld=%b, required 0/0", fg_valid_s, fg_valid);
      end
      // accumulator restarts at 1 when an increment follows the pulse
      send_line(2, 64'h0, 10'd0);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      checks++;
      if (fg_count_s !== 4'd1) begin
         errors++;
         $display("FAIL restart_latch: cnt=%0d, required 1", fg_count_s);
      end
      idle(4);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      checks++;
      if (fg_count_s !== 4'd1 || fg_valid_s !== 1'b1) begin
         errors++;
         $display("FAIL restart_one: vld=%b cnt=%0d, required vld=1 cnt=1", fg_valid_s, fg_count_s);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_composite();
      test_line_edges();
      test_roi();
      test_saturation();
      test_reset_midline();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
